// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port unified memory between the instruction-fetch
// requester and the data requester. Data has fixed priority. A starvation
// counter forces a fetch grant after STARVE_MAX data grants are made while a
// fetch is waiting. if_flush discards the fetch in flight, or blocks a fetch
// that is about to be granted.
//
// Ports
//   clk, reset                   clock, synchronous active-high reset
//   if_req/if_addr/if_flush      fetch request side
//   if_ack/if_rdata              fetch completion pulse and instruction
//   d_req/d_we/d_addr/d_wdata    data request side
//   d_funct3                     data access size/sign
//   d_ack/d_rdata                data completion pulse and load data
//   mem_req/mem_we/mem_addr      memory request, held until mem_ack
//   mem_wdata/mem_funct3         memory write data and size/sign
//   mem_ack/mem_rdata            memory completion pulse and read data
//
// state   | meaning
// IDLE    | no transaction in flight; arbitrate and latch the winner
// IF_BUSY | fetch on the memory port, waiting for mem_ack
// D_BUSY  | data access on the memory port, waiting for mem_ack
module mem_port_arbiter #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [2:0]        d_funct3,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_funct3,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state;
    logic [3:0] starve_cnt;
    logic       drop;

    logic if_elig;
    logic d_elig;
    logic grant_if;
    logic grant_d;

    // A requester whose ack is high this cycle is still holding its old
    // request, so it is masked to avoid a duplicate grant.
    always_comb begin
        if_elig  = if_req && !if_flush && !if_ack;
        d_elig   = d_req && !d_ack;
        grant_if = if_elig && (!d_elig || (starve_cnt == STARVE_LIM));
        grant_d  = d_elig && !grant_if;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            drop       <= 1'b0;
            if_ack     <= 1'b0;
            if_rdata   <= '0;
            d_ack      <= 1'b0;
            d_rdata    <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_funct3 <= '0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    drop <= 1'b0;
                    if (!if_req) begin
                        starve_cnt <= '0;
                    end
                    if (grant_if) begin
                        state      <= IF_BUSY;
                        starve_cnt <= '0;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= if_addr;
                        mem_wdata  <= '0;
                        mem_funct3 <= 3'b010;
                    end else if (grant_d) begin
                        state      <= D_BUSY;
                        mem_req    <= 1'b1;
                        mem_we     <= d_we;
                        mem_addr   <= d_addr;
                        mem_wdata  <= d_wdata;
                        mem_funct3 <= d_funct3;
                        if (if_req && (starve_cnt != STARVE_LIM)) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                    end
                end
                IF_BUSY: begin
                    if (if_flush) begin
                        drop <= 1'b1;
                    end
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        drop    <= 1'b0;
                        // A flush in the completion cycle also discards.
                        if (!drop && !if_flush) begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end
                end
                D_BUSY: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        d_ack   <= 1'b1;
                        // Stores leave the previous load data in place.
                        if (!mem_we) begin
                            d_rdata <= mem_rdata;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule
